// File: rtl/pfb_mac_sched_if.sv
// Frame-start handshake and MAC-chain control bundle between the PFB scheduler
// (slave) and the host / DSP cascade (master).
interface pfb_mac_sched_if #(
    parameter int PHASE_LOG2 = 6,
    parameter int TAP_LOG2   = 3,
    parameter int BUF_AW     = 10
);
    logic                           start_valid;
    logic [BUF_AW-1:0]              start_base;
    logic                           start_ready;
    logic [PHASE_LOG2+TAP_LOG2-1:0] coef_addr;
    logic [BUF_AW-1:0]              buf_addr;
    logic                           mac_en;
    logic                           mac_first;
    logic                           mac_last;
    logic                           dout_valid;
    logic [PHASE_LOG2-1:0]          dout_phase;
    logic                           dout_last;
    logic                           busy;

    modport master (
        output start_valid, start_base,
        input  start_ready, coef_addr, buf_addr, mac_en, mac_first, mac_last,
               dout_valid, dout_phase, dout_last, busy
    );

    modport slave (
        input  start_valid, start_base,
        output start_ready, coef_addr, buf_addr, mac_en, mac_first, mac_last,
               dout_valid, dout_phase, dout_last, busy
    );
endinterface

// File: rtl/pfb_mac_sched.sv
// Polyphase filterbank MAC scheduler: walks phase x tap per frame, drives the MAC
// chain and tags each rounded result with its phase after the pipeline latency.
module pfb_mac_sched #(
    parameter int PHASE_LOG2 = 6,
    parameter int TAP_LOG2   = 3,
    parameter int BUF_AW     = 10,
    parameter int PIPE_LAT   = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    pfb_mac_sched_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a frame start, start_ready high
    // RUN   | issuing one tap per ce cycle
    // DRAIN | final phase still inside the delay line
    localparam int CW = PHASE_LOG2 + TAP_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [PHASE_LOG2-1:0] phase;
        logic                  last;
    } dl_t;

    state_t                state_q, state_d;
    logic [PHASE_LOG2-1:0] phase_q, phase_d;
    logic [TAP_LOG2-1:0]   tap_q, tap_d;
    logic [BUF_AW-1:0]     base_q, base_d;
    logic                  start_ready_q, start_ready_d;
    logic                  busy_q, busy_d;
    logic                  mac_en_q, mac_en_d;
    logic                  mac_first_q, mac_first_d;
    logic                  mac_last_q, mac_last_d;
    logic [CW-1:0]         coef_addr_q, coef_addr_d;
    logic [BUF_AW-1:0]     buf_addr_q, buf_addr_d;
    dl_t                   dl_q [PIPE_LAT];
    dl_t                   dl_d [PIPE_LAT];
    logic                  accept;
    logic [PHASE_LOG2-1:0] issue_phase;

    assign accept      = bus.start_valid && start_ready_q;
    assign issue_phase = coef_addr_q[CW-1:TAP_LOG2];

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        tap_d         = tap_q;
        base_d        = base_q;
        start_ready_d = start_ready_q;
        mac_en_d      = 1'b0;
        mac_first_d   = 1'b0;
        mac_last_d    = 1'b0;
        coef_addr_d   = '0;
        buf_addr_d    = '0;

        case (state_q)
            IDLE: begin
                start_ready_d = !accept;
                if (accept) begin
                    base_d  = bus.start_base;
                    phase_d = '0;
                    tap_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                mac_en_d    = 1'b1;
                coef_addr_d = {phase_q, tap_q};
                // {tap,phase} == tap*2^PHASE_LOG2 + phase; the add wraps at 2^BUF_AW
                buf_addr_d  = base_q + BUF_AW'({tap_q, phase_q});
                mac_first_d = (tap_q == '0);
                mac_last_d  = &tap_q;
                tap_d       = tap_q + TAP_LOG2'(1);
                if (&tap_q) begin
                    phase_d = phase_q + PHASE_LOG2'(1);
                    if (&phase_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dl_q[PIPE_LAT-1].valid && dl_q[PIPE_LAT-1].last) begin
                    state_d       = IDLE;
                    start_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Delay line is fed from the registered issue outputs so dout trails mac_last by PIPE_LAT.
    always_comb begin
        dl_d[0] = '{valid: mac_last_q, phase: issue_phase, last: mac_last_q && (&issue_phase)};
        for (int i = 1; i < PIPE_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            tap_q         <= '0;
            base_q        <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_first_q   <= 1'b0;
            mac_last_q    <= 1'b0;
            coef_addr_q   <= '0;
            buf_addr_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else if (ce) begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            tap_q         <= tap_d;
            base_q        <= base_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            mac_en_q      <= mac_en_d;
            mac_first_q   <= mac_first_d;
            mac_last_q    <= mac_last_d;
            coef_addr_q   <= coef_addr_d;
            buf_addr_q    <= buf_addr_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.busy        = busy_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.mac_first   = mac_first_q;
    assign bus.mac_last    = mac_last_q;
    assign bus.coef_addr   = coef_addr_q;
    assign bus.buf_addr    = buf_addr_q;
    assign bus.dout_valid  = dl_q[PIPE_LAT-1].valid;
    assign bus.dout_phase  = dl_q[PIPE_LAT-1].phase;
    assign bus.dout_last   = dl_q[PIPE_LAT-1].last;
endmodule

// File: tb/tb_pfb_mac_sched.sv
// Bench for pfb_mac_sched: a frame-level reference model predicts every issue and
// dout event by ce-cycle number; one negedge process compares the DUT against it.
module tb_pfb_mac_sched;
    localparam int PL  = 6;
    localparam int TL  = 3;
    localparam int AW  = 10;
    localparam int LAT = 5;
    localparam int NP  = 1 << PL;
    localparam int NT  = 1 << TL;

    typedef struct {
        int         t;
        int         j;
        logic [8:0] coef;
        logic [9:0] ba;
        logic       first;
        logic       last;
    } iss_t;

    typedef struct {
        int         t;
        logic [5:0] phase;
        logic       last;
    } dout_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;

    pfb_mac_sched_if #(.PHASE_LOG2(PL), .TAP_LOG2(TL), .BUF_AW(AW)) bus ();

    pfb_mac_sched #(.PHASE_LOG2(PL), .TAP_LOG2(TL), .BUF_AW(AW), .PIPE_LAT(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int    n_ce, ready_at, acc_cnt, mac_cnt, dout_cnt, last_j;
    bit    m_ready, m_busy, ce_fresh;
    int    acc_t[$];
    iss_t  iq[$];
    dout_t dq[$];
    logic [8:0] obs_coef [NP*NT];
    logic [9:0] obs_buf  [NP*NT];
    logic [5:0] obs_dph  [NP];
    int    ce_mode = 0;
    bit    rand_base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {bus.start_ready, bus.coef_addr, bus.buf_addr, bus.mac_en, bus.mac_first,
                bus.mac_last, bus.dout_valid, bus.dout_phase, bus.dout_last, bus.busy};
    endfunction

    // Frame accepted on ce edge number a: tap j of the frame is issued on edge a+1+j.
    task automatic accept_frame(input logic [9:0] base);
        int a;
        a = n_ce;
        m_ready = 0;
        m_busy  = 1;
        acc_cnt++;
        acc_t.push_back(a);
        mac_cnt  = 0;
        dout_cnt = 0;
        last_j   = -1;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < NT; k++) begin
                iss_t e;
                e.j     = p * NT + k;
                e.t     = a + 1 + e.j;
                e.coef  = 9'(e.j);
                e.ba    = 10'((int'(base) + k * NP + p) % (1 << AW));
                e.first = (k == 0);
                e.last  = (k == NT - 1);
                iq.push_back(e);
                if (e.last) dq.push_back('{t: e.t + LAT, phase: 6'(p), last: (p == NP - 1)});
            end
        end
        ready_at = a + NP * NT + LAT + 1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_ce = 0;
            ready_at = 1;
            m_ready = 0;
            m_busy = 0;
            ce_fresh = 0;
            iq.delete();
            dq.delete();
        end else begin
            ce_fresh = ce;
            if (ce) begin
                n_ce++;
                if (m_ready && bus.start_valid) accept_frame(bus.start_base);
                else if (n_ce == ready_at) begin
                    m_ready = 1;
                    m_busy  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit    exp_en, exp_dv;
        iss_t  e;
        dout_t d;
        if (!reset_n) begin
            chk("rst_outs", all_outs(), 32'd0);
        end else if (ce_fresh) begin
            exp_en = (iq.size() > 0) && (iq[0].t == n_ce);
            chk("mac_en", {31'd0, bus.mac_en}, {31'd0, exp_en});
            if (bus.mac_en) mac_cnt++;
            if (exp_en) begin
                e = iq.pop_front();
                chk("coef_addr", 32'(bus.coef_addr), 32'(e.coef));
                chk("buf_addr", 32'(bus.buf_addr), 32'(e.ba));
                chk("mac_first", {31'd0, bus.mac_first}, {31'd0, e.first});
                chk("mac_last", {31'd0, bus.mac_last}, {31'd0, e.last});
                obs_coef[e.j] = bus.coef_addr;
                obs_buf[e.j]  = bus.buf_addr;
                last_j = e.j;
            end
            exp_dv = (dq.size() > 0) && (dq[0].t == n_ce);
            chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, exp_dv});
            if (bus.dout_valid) begin
                if (dout_cnt < NP) obs_dph[dout_cnt] = bus.dout_phase;
                dout_cnt++;
            end
            if (exp_dv) begin
                d = dq.pop_front();
                chk("dout_phase", 32'(bus.dout_phase), 32'(d.phase));
                chk("dout_last", {31'd0, bus.dout_last}, {31'd0, d.last});
            end
            chk("start_ready", {31'd0, bus.start_ready}, {31'd0, m_ready});
            chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        end
    end

    always @(negedge clk) begin
        case (ce_mode)
            1:       ce = ~ce;
            2:       ce = ($urandom_range(3) != 0);
            default: ce = 1'b1;
        endcase
        if (rand_base) bus.start_base = 10'($urandom);
    end

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (!(m_ready && reset_n) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, bus.start_ready}, 32'd1);
    endtask

    task automatic start_frame(input logic [9:0] base);
        int old;
        int n = 0;
        wait_ready(3000, "ready_before_start");
        old = acc_cnt;
        bus.start_base  = base;
        bus.start_valid = 1'b1;
        while (acc_cnt == old && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.start_valid = 1'b0;
        chk("accept_seen", acc_cnt - old, 32'd1);
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, "_mac_cnt"}, mac_cnt, NP * NT);
        chk({tag, "_dout_cnt"}, dout_cnt, NP);
    endtask

    initial begin
        int old, n;
        bus.start_valid = 1'b0;
        bus.start_base  = '0;
        acc_cnt = 0;
        mac_cnt = 0;
        dout_cnt = 0;
        last_j = -1;

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, bus.start_ready}, 32'd1);
        chk("busy_after_rst", {31'd0, bus.busy}, 32'd0);

        start_frame(10'd0);
        wait_ready(3000, "frame0_done");
        frame_counts("frame0");
        chk("tap10_coef", 32'(obs_coef[10]), 32'd10);
        chk("tap10_buf", 32'(obs_buf[10]), 32'd129);
        chk("first_dout_phase", 32'(obs_dph[0]), 32'd0);
        chk("last_dout_phase", 32'(obs_dph[NP-1]), 32'd63);

        start_frame(10'd1000);
        wait_ready(3000, "wrap_done");
        frame_counts("wrap");
        chk("wrap_buf_t0", 32'(obs_buf[0]), 32'd1000);
        chk("wrap_buf_t1", 32'(obs_buf[1]), 32'd40);

        ce_mode = 1;
        start_frame(10'($urandom));
        wait_ready(3000, "toggle_done");
        frame_counts("toggle");

        ce_mode = 2;
        wait_ready(3000, "held_idle");
        old = acc_cnt;
        rand_base = 1;
        bus.start_valid = 1'b1;
        n = 0;
        while (acc_cnt < old + 2 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        bus.start_valid = 1'b0;
        rand_base = 0;
        chk("held_two_accepts", acc_cnt - old, 32'd2);
        chk("back_to_back_gap", acc_t[$] - acc_t[$-1], 32'd519);
        wait_ready(3000, "held_done");
        frame_counts("held");

        for (int f = 0; f < 3; f++) begin
            start_frame(10'($urandom));
            wait_ready(3000, "rand_done");
            frame_counts("rand");
        end

        ce_mode = 0;
        start_frame(10'($urandom));
        n = 0;
        while (last_j < 200 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_tap200", {31'd0, last_j >= 200}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_outs", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        start_frame(10'd0);
        wait_ready(3000, "post_rst_done");
        frame_counts("post_rst");
        chk("post_rst_coef0", 32'(obs_coef[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
